// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered IF/ID -> ID/EX decode for the RV32I mini core.
// Decodes one instruction per cycle into control-word fields, register indices and a
// sign-extended immediate, held behind a valid/ready handshake. A dependent instruction
// that follows a load gets one bubble, flush discards the held and incoming word, and
// load-use bubbles are counted in a saturating counter.
module riscv_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             selimregb,
    output logic             selwsource,
    output logic             writereg,
    output logic             readmem,
    output logic             writemem,
    output logic             out_illegal,
    output logic [2:0]       aluop,
    output logic [1:0]       selpctype,
    output logic [2:0]       compop,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    logic            d_selimregb;
    logic            d_selwsource;
    logic            d_writereg;
    logic            d_readmem;
    logic            d_writemem;
    logic            d_illegal;
    logic [2:0]      d_aluop;
    logic [1:0]      d_selpctype;
    logic [2:0]      d_compop;
    logic [XLEN-1:0] d_imm;

    // Combinational decode; anything not matched stays illegal with every enable and the immediate cleared.
    always_comb begin
        d_selimregb  = 1'b0;
        d_selwsource = 1'b0;
        d_writereg   = 1'b0;
        d_readmem    = 1'b0;
        d_writemem   = 1'b0;
        d_illegal    = 1'b1;
        d_aluop      = 3'b000;
        d_selpctype  = 2'b00;
        d_compop     = 3'b000;
        d_imm        = '0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b100) begin
                    d_illegal   = 1'b0;
                    d_selimregb = 1'b1;
                    d_writereg  = 1'b1;
                    d_imm       = imm_i;
                    case (funct3)
                        3'b111:  d_aluop = ALU_AND;
                        3'b110:  d_aluop = ALU_OR;
                        3'b100:  d_aluop = ALU_XOR;
                        default: d_aluop = ALU_ADD;
                    endcase
                end
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 &&
                    (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b100)) begin
                    d_illegal  = 1'b0;
                    d_writereg = 1'b1;
                    case (funct3)
                        3'b111:  d_aluop = ALU_AND;
                        3'b110:  d_aluop = ALU_OR;
                        3'b100:  d_aluop = ALU_XOR;
                        default: d_aluop = ALU_ADD;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    d_illegal  = 1'b0;
                    d_writereg = 1'b1;
                    d_aluop    = ALU_SUB;
                end else if (ENABLE_M && funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    d_illegal  = 1'b0;
                    d_writereg = 1'b1;
                    d_aluop    = ALU_MUL;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    d_illegal    = 1'b0;
                    d_selimregb  = 1'b1;
                    d_readmem    = 1'b1;
                    d_selwsource = 1'b1;
                    d_writereg   = 1'b1;
                    d_aluop      = ALU_ADD;
                    d_imm        = imm_i;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    d_illegal   = 1'b0;
                    d_selimregb = 1'b1;
                    d_writemem  = 1'b1;
                    d_aluop     = ALU_ADD;
                    d_imm       = imm_s;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    d_illegal   = 1'b0;
                    d_selpctype = PC_BRANCH;
                    d_compop    = funct3;
                    d_aluop     = ALU_SUB;
                    d_imm       = imm_b;
                end
            end
            OPC_JAL: begin
                d_illegal   = 1'b0;
                d_selpctype = PC_JUMP;
                d_writereg  = 1'b1;
                d_imm       = imm_j;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
        if (rd == 5'd0) begin
            d_writereg = 1'b0;
        end
    end

    logic uses_rs1;
    logic uses_rs2;
    logic hazard;
    logic accept;

    assign uses_rs1 = (opcode != OPC_JAL);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    // Only a held load can create a load-use hazard; readmem is set for legal LW alone.
    assign hazard = out_valid && readmem && (out_rd != 5'd0) && in_valid &&
                    ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register: flush beats accept, accept beats drain, otherwise hold under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            selimregb   <= 1'b0;
            selwsource  <= 1'b0;
            writereg    <= 1'b0;
            readmem     <= 1'b0;
            writemem    <= 1'b0;
            out_illegal <= 1'b0;
            aluop       <= '0;
            selpctype   <= '0;
            compop      <= '0;
            stall_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= d_imm;
            out_rs1     <= rs1;
            out_rs2     <= rs2;
            out_rd      <= rd;
            selimregb   <= d_selimregb;
            selwsource  <= d_selwsource;
            writereg    <= d_writereg;
            readmem     <= d_readmem;
            writemem    <= d_writemem;
            out_illegal <= d_illegal;
            aluop       <= d_aluop;
            selpctype   <= d_selpctype;
            compop      <= d_compop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            if (hazard && stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
